// File: rtl/sync_dpram_be.sv
// sync_dpram_be: single-clock simple dual-port RAM with per-lane write enables,
// 1- or 2-cycle registered read, selectable read-during-write result and an
// optional hardware clear that zeroes every word after reset.
module sync_dpram_be #(
   parameter int ADDRSIZE       = 4,
   parameter int DATASIZE       = 8,
   parameter int LANE           = 8,
   parameter int RD_LAT         = 1,
   parameter int RDW_NEW        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wen,
   input  logic [DATASIZE/LANE-1:0]   wbe,
   input  logic [ADDRSIZE-1:0]        waddr,
   input  logic [DATASIZE-1:0]        wdata,
   input  logic                       ren,
   input  logic [ADDRSIZE-1:0]        raddr,
   output logic [DATASIZE-1:0]        rdata,
   output logic                       rvalid,
   output logic                       init_busy
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam int NLANE = DATASIZE / LANE;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // Parameter sanity, caught while elaborating rather than in silicon.
   generate
      if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_rd_lat
         $error("sync_dpram_be: RD_LAT must be 1 or 2");
      end
      if ((DATASIZE % LANE) != 0) begin : g_bad_lane
         $error("sync_dpram_be: DATASIZE must be a multiple of LANE");
      end
   endgenerate

   logic [DATASIZE-1:0] mem [DEPTH];

   logic [0:0]          state_q, state_d;
   logic [ADDRSIZE-1:0] clr_cnt_q, clr_cnt_d;
   logic                busy;

   assign busy      = (state_q == ST_CLEAR);
   assign init_busy = busy;

   // Clear sequencer: walk clr_cnt over every address, leave CLEAR after the last one.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (&clr_cnt_q) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Sequencer state; reset restarts the clear from address 0 when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Write port mux: the clear owns the port while busy, user writes are dropped.
   logic [ADDRSIZE-1:0] mw_addr;
   logic [DATASIZE-1:0] mw_data;
   logic [NLANE-1:0]    mw_be;

   always_comb begin
      mw_addr = waddr;
      mw_data = wdata;
      mw_be   = '0;
      if (!rst) begin
         if (busy) begin
            mw_addr = clr_cnt_q;
            mw_data = '0;
            mw_be   = '1;
         end else if (wen) begin
            mw_be = wbe;
         end
      end
   end

   // Memory array write, one enable per lane; contents are never reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NLANE; i++) begin
         if (mw_be[i]) begin
            mem[mw_addr][i*LANE +: LANE] <= mw_data[i*LANE +: LANE];
         end
      end
   end

   // Read word with optional same-edge bypass of the enabled write lanes.
   logic [DATASIZE-1:0] rd_word;
   logic [DATASIZE-1:0] rd_merged;
   logic                rdw_hit;
   logic                ren_ok;

   assign rd_word = mem[raddr];
   assign rdw_hit = (RDW_NEW != 0) && wen && (waddr == raddr);
   assign ren_ok  = ren && !busy;

   generate
      for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
         assign rd_merged[gi*LANE +: LANE] = (rdw_hit && wbe[gi]) ? wdata[gi*LANE +: LANE]
                                                                  : rd_word[gi*LANE +: LANE];
      end
   endgenerate

   logic [DATASIZE-1:0] rd1_data_q;
   logic                rd1_valid_q;

   // First read stage: capture on an accepted read, otherwise hold data and drop valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd1_data_q  <= '0;
         rd1_valid_q <= 1'b0;
      end else begin
         rd1_valid_q <= ren_ok;
         if (ren_ok) begin
            rd1_data_q <= rd_merged;
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DATASIZE-1:0] rd2_data_q;
         logic                rd2_valid_q;

         // Second read stage: straight copy of the first stage, no hazard handling.
         always_ff @(posedge clk) begin
            if (rst) begin
               rd2_data_q  <= '0;
               rd2_valid_q <= 1'b0;
            end else begin
               rd2_data_q  <= rd1_data_q;
               rd2_valid_q <= rd1_valid_q;
            end
         end

         assign rdata  = rd2_data_q;
         assign rvalid = rd2_valid_q;
      end else begin : g_lat1
         assign rdata  = rd1_data_q;
         assign rvalid = rd1_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_dpram_be.sv
// tb_sync_dpram_be: directed checks of two RAM variants sharing one stimulus stream.
// dut0: 32-bit, RD_LAT=1, old-data on read-during-write.
// dut1: 32-bit, RD_LAT=2, lane-merged new data on read-during-write.
module tb_sync_dpram_be;

   logic        clk;
   logic        rst;
   logic        wen;
   logic [3:0]  wbe;
   logic [3:0]  waddr;
   logic [31:0] wdata;
   logic        ren;
   logic [3:0]  raddr;

   logic [31:0] rdata0, rdata1;
   logic        rvalid0, rvalid1;
   logic        init_busy0, init_busy1;

   int n_checks = 0;
   int n_fail   = 0;

   sync_dpram_be #(
      .ADDRSIZE(4), .DATASIZE(32), .LANE(8), .RD_LAT(1), .RDW_NEW(0), .CLEAR_ON_RESET(1)
   ) dut0 (
      .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .init_busy(init_busy0)
   );

   sync_dpram_be #(
      .ADDRSIZE(4), .DATASIZE(32), .LANE(8), .RD_LAT(2), .RDW_NEW(1), .CLEAR_ON_RESET(1)
   ) dut1 (
      .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .init_busy(init_busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      wen = 1'b1; waddr = a; wdata = d; wbe = be;
      @(negedge clk);
      wen = 1'b0; wbe = 4'h0;
      $display("write addr=%0d data=%h be=%b", a, d, be);
   endtask

   // Read one address; dut0 answers one cycle later, dut1 two cycles later.
   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
      @(negedge clk);
      ren = 1'b1; raddr = a;
      @(negedge clk);
      ren = 1'b0;
      check_val({tag, "_v0"}, 32'(rvalid0), 32'd1);
      check_val({tag, "_d0"}, rdata0, e0);
      @(negedge clk);
      check_val({tag, "_v1"}, 32'(rvalid1), 32'd1);
      check_val({tag, "_d1"}, rdata1, e1);
      $display("read  addr=%0d dut0=%h dut1=%h", a, rdata0, rdata1);
   endtask

   // Same-edge write and read of one address.
   task automatic rdw(input string tag, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] e0, input logic [31:0] e1);
      @(negedge clk);
      wen = 1'b1; waddr = a; wdata = d; wbe = be;
      ren = 1'b1; raddr = a;
      @(negedge clk);
      wen = 1'b0; wbe = 4'h0; ren = 1'b0;
      check_val({tag, "_v0"}, 32'(rvalid0), 32'd1);
      check_val({tag, "_d0"}, rdata0, e0);
      @(negedge clk);
      check_val({tag, "_v1"}, 32'(rvalid1), 32'd1);
      check_val({tag, "_d1"}, rdata1, e1);
      $display("rdw   addr=%0d dut0=%h dut1=%h", a, rdata0, rdata1);
   endtask

   // Called at the negedge where rst was just released; counts busy cycles.
   task automatic clear_wait(input string tag);
      int n0 = 0;
      int n1 = 0;
      int vseen = 0;
      for (int i = 0; i < 40; i++) begin
         if (!init_busy0 && !init_busy1) break;
         if (init_busy0) n0++;
         if (init_busy1) n1++;
         if (rvalid0 || rvalid1) vseen++;
         @(negedge clk);
      end
      wen = 1'b0; ren = 1'b0; wbe = 4'h0;
      check_val({tag, "_busy0"}, 32'(n0), 32'd16);
      check_val({tag, "_busy1"}, 32'(n1), 32'd16);
      check_val({tag, "_novalid"}, 32'(vseen), 32'd0);
      $display("clear %s busy0=%0d busy1=%0d", tag, n0, n1);
   endtask

   initial begin
      int vseen;
      rst = 1'b1; wen = 1'b0; ren = 1'b0; wbe = 4'h0;
      waddr = 4'd0; wdata = 32'h0; raddr = 4'd0;

      // Reset state.
      repeat (3) @(negedge clk);
      check_val("rst_v0", 32'(rvalid0), 32'd0);
      check_val("rst_d0", rdata0, 32'h0);
      check_val("rst_v1", 32'(rvalid1), 32'd0);
      check_val("rst_d1", rdata1, 32'h0);
      check_val("rst_busy0", 32'(init_busy0), 32'd1);
      check_val("rst_busy1", 32'(init_busy1), 32'd1);

      // Clear with wen/ren held high: nothing lands, nothing is read.
      wen = 1'b1; ren = 1'b1; wbe = 4'hF; waddr = 4'd2; wdata = 32'hDEADBEEF; raddr = 4'd2;
      rst = 1'b0;
      clear_wait("clr");
      for (int a = 0; a < 16; a++) begin
         rd($sformatf("clr_rd%0d", a), 4'(a), 32'h0, 32'h0);
      end

      // Byte lanes.
      wr(4'd3, 32'hAABBCCDD, 4'b1111);
      wr(4'd3, 32'h11223344, 4'b0101);
      rd("lanes", 4'd3, 32'hAA22CC44, 32'hAA22CC44);
      wr(4'd3, 32'hFFFFFFFF, 4'b0000);
      rd("be_zero", 4'd3, 32'hAA22CC44, 32'hAA22CC44);

      // Read-during-write policy.
      rdw("rdw_full", 4'd5, 32'h0000005A, 4'b1111, 32'h00000000, 32'h0000005A);
      rd("rdw_after", 4'd5, 32'h0000005A, 32'h0000005A);
      rdw("rdw_part", 4'd3, 32'h99887766, 4'b0011, 32'hAA22CC44, 32'hAA227766);
      rd("rdw_part_after", 4'd3, 32'hAA227766, 32'hAA227766);

      // Address wrap.
      wr(4'd15, 32'hF00DF00D, 4'hF);
      wr(4'd0, 32'h0BADCAFE, 4'hF);
      rd("wrap15", 4'd15, 32'hF00DF00D, 32'hF00DF00D);
      rd("wrap0", 4'd0, 32'h0BADCAFE, 32'h0BADCAFE);

      // Streaming reads over addresses 0..7.
      for (int k = 0; k < 8; k++) begin
         wr(4'(k), 32'hC0DE0000 + 32'(k), 4'hF);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check_val($sformatf("strm_v0_c%0d", c), 32'(rvalid0), (c >= 1 && c <= 8) ? 32'd1 : 32'd0);
         if (c >= 1 && c <= 8) check_val($sformatf("strm_d0_c%0d", c), rdata0, 32'hC0DE0000 + 32'(c - 1));
         check_val($sformatf("strm_v1_c%0d", c), 32'(rvalid1), (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
         if (c >= 2 && c <= 9) check_val($sformatf("strm_d1_c%0d", c), rdata1, 32'hC0DE0000 + 32'(c - 2));
         $display("stream c=%0d v0=%0d d0=%h v1=%0d d1=%h", c, rvalid0, rdata0, rvalid1, rdata1);
         if (c < 8) begin
            ren = 1'b1; raddr = 4'(c);
         end else begin
            ren = 1'b0;
         end
      end

      // Reset with reads in flight: dut1 never reports them.
      @(negedge clk);
      ren = 1'b1; raddr = 4'd3;
      @(negedge clk);
      check_val("inflt_v1_a", 32'(rvalid1), 32'd0);
      raddr = 4'd4; rst = 1'b1;
      @(negedge clk);
      ren = 1'b0;
      check_val("inflt_v0_b", 32'(rvalid0), 32'd0);
      check_val("inflt_v1_b", 32'(rvalid1), 32'd0);
      check_val("inflt_d1_b", rdata1, 32'h0);
      @(negedge clk);
      check_val("inflt_v1_c", 32'(rvalid1), 32'd0);
      rst = 1'b0;
      $display("reset with reads in flight done");

      // Let the clear reach address 9, then reset again.
      vseen = 0;
      repeat (9) begin
         @(negedge clk);
         if (rvalid0 || rvalid1) vseen++;
      end
      check_val("midclr_busy0", 32'(init_busy0), 32'd1);
      check_val("midclr_novalid", 32'(vseen), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_wait("reclr");
      rd("reclr15", 4'd15, 32'h0, 32'h0);
      rd("reclr3", 4'd3, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
